// File: rtl/synth_pkg.sv
// Shared constants and types for the I2S sine tone synthesiser.
//   DIV_W      : width of the free-running frame divider (2048 clk per frame)
//   *_BIT      : divider bits that become the DAC clocks
//   SLOT_DELAY : I2S one-bit delay after the word-select edge
//   DATA_BITS  : MSB-justified word length sent per channel
package synth_pkg;

  localparam int DIV_W      = 11;
  localparam int MCLK_BIT   = 1;
  localparam int SCK_BIT    = 4;
  localparam int LRCK_BIT   = 10;
  localparam int SLOT_DELAY = 0;
  localparam int DATA_BITS  = 24;
  localparam int SAMPLE_W   = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sine_lut.sv
// 256-entry sine ROM: o_sample = round(127*sin(2*pi*i_phase/256)), two's
// complement. Only the first quarter wave (0..64) is stored; the other three
// quarters come from mirror and sign symmetry, which is exact because the
// rounding is symmetric about zero.
//   i_phase  : 8-bit phase index
//   o_sample : signed 8-bit sample (combinational)
module sine_lut
  import synth_pkg::*;
(
  input  logic [7:0] i_phase,
  output sample_t    o_sample
);

  localparam logic [6:0] QTR [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

  logic [6:0] w_idx;
  logic [6:0] w_mag;
  logic [7:0] w_tmp;

  always_comb begin
    // Position within the half wave; 65..127 mirror back onto 63..1.
    w_tmp = 8'd128 - {1'b0, i_phase[6:0]};
    if (i_phase[6] && (i_phase[5:0] != 6'd0)) w_idx = w_tmp[6:0];
    else                                      w_idx = i_phase[6:0];
    w_mag = QTR[w_idx];
    // Second half wave is the negated first half.
    if (i_phase[7]) o_sample = sample_t'(8'd0 - {1'b0, w_mag});
    else            o_sample = sample_t'({1'b0, w_mag});
  end

endmodule

// File: rtl/i2s_sine_synth.sv
// Sine tone synthesiser driving a CS4344-class I2S DAC.
// One 11-bit divider produces every clock; the phase accumulator steps once
// per 2048-clk frame and the sine sample is shifted out MSB first with the
// I2S one-bit delay, identical on both channels.
//   clk         : 100 MHz system clock
//   rst         : async active-low reset
//   mclk/sck/lrck : DAC clocks (clk/4, clk/32, clk/2048)
//   sdout       : serial data, changes on sck falling edges
//   phase, s, led : debug view of accumulator and current sample
//   sample_tick : one-clk pulse while the divider sits at its last count
module i2s_sine_synth
  import synth_pkg::*;
#(
  parameter logic [7:0] PHASE_INC = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] led,
  output logic       mclk,
  output logic       lrck,
  output logic       sck,
  output logic       sdout,
  output logic [7:0] phase,
  output logic [7:0] s,
  output logic       sample_tick
);

  localparam logic [DIV_W-1:0] DIV_PRE_END = {{(DIV_W-1){1'b1}}, 1'b0};
  localparam logic [4:0]       FIRST_SLOT  = 5'(SLOT_DELAY + 1);
  localparam logic [4:0]       LAST_SLOT   = 5'(SLOT_DELAY + DATA_BITS);

  logic [DIV_W-1:0]     r_div;
  logic [7:0]           r_phase;
  logic                 r_sdout;
  logic                 r_tick;

  sample_t              w_s;
  logic                 w_frame_end;
  logic                 w_slot_end;
  logic [4:0]           w_next_slot;
  logic [4:0]           w_bidx;
  logic [DATA_BITS-1:0] w_word;
  logic                 w_bit;

  sine_lut u_lut (
    .i_phase  (r_phase),
    .o_sample (w_s)
  );

  assign w_frame_end = &r_div;
  assign w_slot_end  = &r_div[SCK_BIT:0];
  assign w_word      = {w_s, {(DATA_BITS-SAMPLE_W){1'b0}}};

  // Lookahead: at the end of each sck period pick the bit for the slot that
  // starts next, so sdout is a plain flop aligned with the sck falling edge.
  // The phase update lands on the same edge as slot 0, whose bit is always
  // zero, so the new sample is already settled when slot 1 is loaded.
  always_comb begin
    w_next_slot = r_div[LRCK_BIT-1:SCK_BIT+1] + 5'd1;
    w_bidx      = 5'(DATA_BITS) - (w_next_slot - 5'(SLOT_DELAY));
    w_bit       = 1'b0;
    if (w_next_slot >= FIRST_SLOT && w_next_slot <= LAST_SLOT)
      w_bit = w_word[w_bidx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_phase <= '0;
      r_sdout <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_div  <= r_div + 1'b1;
      r_tick <= (r_div == DIV_PRE_END);
      if (w_frame_end) r_phase <= r_phase + PHASE_INC;
      if (w_slot_end)  r_sdout <= w_bit;
    end
  end

  assign mclk        = r_div[MCLK_BIT];
  assign sck         = r_div[SCK_BIT];
  assign lrck        = r_div[LRCK_BIT];
  assign sdout       = r_sdout;
  assign sample_tick = r_tick;
  assign phase       = r_phase;
  assign s           = w_s;
  assign led         = w_s;

endmodule

// File: tb/tb_i2s_sine_synth.sv
module tb_i2s_sine_synth;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Three builds: slow tone, quarter-wave steps, silence.
  logic [7:0] led1, ph1, s1;  logic mclk1, lrck1, sck1, sd1, tk1;
  logic [7:0] leda, pha, sa;  logic mclka, lrcka, scka, sda, tka;
  logic [7:0] ledz, phz, sz;  logic mclkz, lrckz, sckz, sdz, tkz;

  i2s_sine_synth #(.PHASE_INC(8'd1)) dut (
    .clk(clk), .rst(rst), .led(led1), .mclk(mclk1), .lrck(lrck1), .sck(sck1),
    .sdout(sd1), .phase(ph1), .s(s1), .sample_tick(tk1));
  i2s_sine_synth #(.PHASE_INC(8'd64)) dut_a (
    .clk(clk), .rst(rst), .led(leda), .mclk(mclka), .lrck(lrcka), .sck(scka),
    .sdout(sda), .phase(pha), .s(sa), .sample_tick(tka));
  i2s_sine_synth #(.PHASE_INC(8'd0)) dut_z (
    .clk(clk), .rst(rst), .led(ledz), .mclk(mclkz), .lrck(lrckz), .sck(sckz),
    .sdout(sdz), .phase(phz), .s(sz), .sample_tick(tkz));

  logic [7:0] lut_p;
  logic [7:0] lut_s;
  sine_lut u_lut (.i_phase(lut_p), .o_sample(lut_s));

  // Clocks elapsed since reset release.
  int cyc;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] sine_ref(input int p);
    real v;
    int  r;
    v = 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return 8'(r);
  endfunction

  function automatic logic [7:0] phase_ref(input int c, input int inc);
    return 8'(((c / 2048) * inc) % 256);
  endfunction

  // Half-frame slot 0 is the I2S delay bit, slots 1..8 carry the sample MSB
  // first, the 16 padding bits and trailing slots are zero.
  function automatic logic sd_ref(input logic [7:0] sv, input int c);
    int slot;
    slot = ((c % 2048) / 32) % 32;
    if (slot >= 1 && slot <= 8) return sv[8 - slot];
    return 1'b0;
  endfunction

  function automatic logic [2:0] clks_ref(input int c);
    int d;
    d = c % 2048;
    return {1'(d / 2), 1'(d / 16), 1'(d / 1024)};  // {mclk, sck, lrck}
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({led1, mclk1, lrck1, sck1, sd1, ph1, s1, tk1} !== 29'd0) begin
      n_fail++; $display("FAIL reset_inc1 got=%h want=0", {led1, mclk1, lrck1, sck1, sd1, ph1, s1, tk1});
    end
    n_chk++;
    if ({leda, mclka, lrcka, scka, sda, pha, sa, tka} !== 29'd0) begin
      n_fail++; $display("FAIL reset_inc64 got=%h want=0", {leda, mclka, lrcka, scka, sda, pha, sa, tka});
    end
    n_chk++;
    if ({ledz, mclkz, lrckz, sckz, sdz, phz, sz, tkz} !== 29'd0) begin
      n_fail++; $display("FAIL reset_inc0 got=%h want=0", {ledz, mclkz, lrckz, sckz, sdz, phz, sz, tkz});
    end
    rst = 1'b1;
  endtask

  task automatic test_clocks();
    int rise_at = -1;
    int fall_at = -1;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      n_chk++;
      if ({mclk1, sck1, lrck1} !== clks_ref(cyc)) begin
        n_fail++; $display("FAIL clocks cyc=%0d got=%b want=%b", cyc, {mclk1, sck1, lrck1}, clks_ref(cyc));
      end
      if (lrck1 && rise_at < 0) rise_at = cyc;
      if (!lrck1 && rise_at >= 0 && fall_at < 0) fall_at = cyc;
    end
    n_chk++;
    if (rise_at != 1024) begin n_fail++; $display("FAIL lrck_first_rise got=%0d want=1024", rise_at); end
    n_chk++;
    if (fall_at != 2048) begin n_fail++; $display("FAIL lrck_first_fall got=%0d want=2048", fall_at); end
  endtask

  task automatic test_frame_strobe();
    int ticks = 0;
    for (int i = 0; i < 3 * 2048; i++) begin
      @(negedge clk);
      n_chk++;
      if (tk1 !== ((cyc % 2048) == 2047)) begin
        n_fail++; $display("FAIL sample_tick cyc=%0d got=%b", cyc, tk1);
      end
      n_chk++;
      if (ph1 !== phase_ref(cyc, 1)) begin
        n_fail++; $display("FAIL phase cyc=%0d got=%0d want=%0d", cyc, ph1, phase_ref(cyc, 1));
      end
      n_chk++;
      if (s1 !== sine_ref(phase_ref(cyc, 1)) || led1 !== s1) begin
        n_fail++; $display("FAIL sample_led cyc=%0d s=%h led=%h want=%h", cyc, s1, led1, sine_ref(phase_ref(cyc, 1)));
      end
      if (tk1) ticks++;
    end
    n_chk++;
    if (ticks != 3) begin n_fail++; $display("FAIL tick_count got=%0d want=3", ticks); end
  endtask

  task automatic test_sine_lut();
    logic [7:0] dp [5] = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd32};
    logic [7:0] dv [5] = '{8'h00, 8'h7F, 8'h00, 8'h81, 8'h5A};
    int start;
    for (int i = 0; i < 5; i++) begin
      lut_p = dp[i]; #1;
      n_chk++;
      if (lut_s !== dv[i]) begin n_fail++; $display("FAIL lut_directed p=%0d got=%h want=%h", dp[i], lut_s, dv[i]); end
    end
    // Full table in random order.
    start = $urandom_range(0, 255);
    for (int i = 0; i < 256; i++) begin
      lut_p = 8'((start + i * 37) % 256); #1;
      n_chk++;
      if (lut_s !== sine_ref(int'(lut_p))) begin
        n_fail++; $display("FAIL lut_table p=%0d got=%h want=%h", lut_p, lut_s, sine_ref(int'(lut_p)));
      end
    end
  endtask

  task automatic test_serial();
    logic [31:0] hl, hr;
    logic [7:0]  sv;
    int guard = 0;
    while ((cyc % 2048) != 0 && guard < 2100) begin @(negedge clk); guard++; end
    n_chk++;
    if ((cyc % 2048) != 0) begin n_fail++; $display("FAIL serial_align cyc=%0d", cyc); end
    for (int f = 0; f < 4; f++) begin
      sv = sine_ref(phase_ref(cyc, 64));
      n_chk++;
      if (pha !== phase_ref(cyc, 64)) begin n_fail++; $display("FAIL serial_phase got=%0d want=%0d", pha, phase_ref(cyc, 64)); end
      hl = '0; hr = '0;
      for (int i = 0; i < 2048; i++) begin
        n_chk++;
        if (sda !== sd_ref(sv, cyc) || {mclka, scka, lrcka} !== clks_ref(cyc)) begin
          n_fail++; $display("FAIL serial_bit cyc=%0d sd=%b want=%b", cyc, sda, sd_ref(sv, cyc));
        end
        if ((cyc % 32) == 16) begin  // just after an sck rising edge
          if (lrcka) hr = {hr[30:0], sda};
          else       hl = {hl[30:0], sda};
        end
        @(negedge clk);
      end
      n_chk++;
      if (hl !== hr) begin n_fail++; $display("FAIL serial_lr_equal left=%h right=%h", hl, hr); end
      if (sv == 8'h7F) begin
        n_chk++;
        if (hl !== 32'h3F80_0000) begin n_fail++; $display("FAIL serial_7f_word got=%h want=3f800000", hl); end
      end
    end
  endtask

  task automatic test_midframe_reset();
    int target;
    int guard = 0;
    target = 650 + $urandom_range(0, 100);
    while ((cyc % 2048) != target && guard < 2100) begin @(negedge clk); guard++; end
    n_chk++;
    if ((cyc % 2048) != target) begin n_fail++; $display("FAIL midreset_align cyc=%0d want=%0d", cyc, target); end
    @(posedge clk); #2;
    rst = 1'b0; #1;
    n_chk++;
    if ({lrck1, sck1, sd1, mclk1, lrcka, scka, sda, mclka} !== 8'd0) begin
      n_fail++; $display("FAIL midreset_clocks got=%b want=0", {lrck1, sck1, sd1, mclk1, lrcka, scka, sda, mclka});
    end
    n_chk++;
    if ({ph1, pha, sa, tka} !== 25'd0) begin n_fail++; $display("FAIL midreset_state got=%h want=0", {ph1, pha, sa, tka}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2300; i++) begin
      @(negedge clk);
      n_chk++;
      if ({mclka, scka, lrcka} !== clks_ref(cyc) || pha !== phase_ref(cyc, 64) ||
          sda !== sd_ref(sine_ref(phase_ref(cyc, 64)), cyc)) begin
        n_fail++; $display("FAIL midreset_restart cyc=%0d clks=%b ph=%0d sd=%b", cyc, {mclka, scka, lrcka}, pha, sda);
      end
    end
  endtask

  task automatic test_phase_inc_zero();
    for (int i = 0; i < 4 * 2048; i++) begin
      @(negedge clk);
      n_chk++;
      if (phz !== 8'd0 || sz !== 8'd0 || ledz !== 8'd0 || sdz !== 1'b0) begin
        n_fail++; $display("FAIL inc0_silence cyc=%0d ph=%0d s=%h sd=%b want=0", cyc, phz, sz, sdz);
      end
      n_chk++;
      if (tkz !== ((cyc % 2048) == 2047)) begin n_fail++; $display("FAIL inc0_tick cyc=%0d got=%b", cyc, tkz); end
    end
  endtask

  initial begin
    lut_p = 8'd0;
    test_reset();
    test_clocks();
    test_frame_strobe();
    test_sine_lut();
    test_serial();
    test_midframe_reset();
    test_phase_inc_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
